// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg
// Shared definitions for the instruction-memory arbiter:
//   - arb_state_t : FSM state encoding (IDLE / BUSY0 / BUSY1 / DRAIN)
//   - GRANT_*     : one-hot grant constants (bit0 = requester 0)
//   - IWIDTH_DEF / AWIDTH_INSTR_DEF : default data and address widths
//   - grant_for() : maps an FSM state to its one-hot grant vector
package imem_arbiter_pkg;

  localparam int IWIDTH_DEF       = 32;
  localparam int AWIDTH_INSTR_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

  function automatic logic [1:0] grant_for(input arb_state_t st);
    logic [1:0] g;
    g = GRANT_NONE;
    case (st)
      ST_BUSY0: g = GRANT_0;
      ST_BUSY1: g = GRANT_1;
      default:  g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/imem_arb_rr.sv
// imem_arb_rr
// Two-input round-robin picker. Purely combinational.
// Ports:
//   syn0, syn1 : request lines of requester 0 / 1
//   rr         : index of the requester served most recently
//   winner     : index of the requester to grant next (only meaningful
//                when at least one request is high)
module imem_arb_rr (
  input  logic syn0,
  input  logic syn1,
  input  logic rr,
  output logic winner
);

  always_comb begin
    winner = 1'b0;
    if (syn0 && syn1) begin
      // Tie: the requester that was not served last time wins.
      winner = ~rr;
    end else if (syn1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter
// Shares one instruction-memory port (syn/ack/last handshake) between the
// fetch stage (requester 0) and a secondary master (requester 1). Grants are
// round-robin and held for a whole burst; a pipeline flush aborts a
// requester-0 transfer.
//
// Optional feature: define IMEM_ARB_TIMEOUT_EN to enable forced release of a
// grant after TIMEOUT cycles without a memory ack (a_o_timeout pulses).
// Without it a_o_timeout is tied low and DRAIN waits for an ack forever.
//
// Ports:
//   a_clk, a_rst              clock, synchronous active-high reset
//   a_i_syn0/1, a_i_addr0/1   requests and addresses from requesters 0/1
//   a_o_ack0/1, a_o_last0/1   ack/last routed to the granted requester
//   a_o_data0/1               memory read data broadcast to both requesters
//   a_o_syn, a_o_addr         request and address towards memory
//   a_i_ack, a_i_last, a_i_data  memory response
//   a_i_flush                 pipeline flush (affects requester 0 only)
//   a_o_grant                 one-hot current grant
//   a_o_timeout               one-cycle pulse on forced release
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; picks a winner among pending requests
// BUSY0 | requester 0 owns the memory port until ack+last or withdrawal
// BUSY1 | requester 1 owns the memory port until ack+last or withdrawal
// DRAIN | flushed fetch outstanding; swallow the next memory ack
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int IWIDTH       = IWIDTH_DEF,
  parameter int AWIDTH_INSTR = AWIDTH_INSTR_DEF,
  parameter int TIMEOUT      = 64,
  parameter int TO_WIDTH     = 7
) (
  input  logic                    a_clk,
  input  logic                    a_rst,
  input  logic                    a_i_syn0,
  input  logic                    a_i_syn1,
  input  logic [AWIDTH_INSTR-1:0] a_i_addr0,
  input  logic [AWIDTH_INSTR-1:0] a_i_addr1,
  output logic                    a_o_ack0,
  output logic                    a_o_ack1,
  output logic                    a_o_last0,
  output logic                    a_o_last1,
  output logic [IWIDTH-1:0]       a_o_data0,
  output logic [IWIDTH-1:0]       a_o_data1,
  output logic                    a_o_syn,
  output logic [AWIDTH_INSTR-1:0] a_o_addr,
  input  logic                    a_i_ack,
  input  logic                    a_i_last,
  input  logic [IWIDTH-1:0]       a_i_data,
  input  logic                    a_i_flush,
  output logic [1:0]              a_o_grant,
  output logic                    a_o_timeout
);

  // The timeout counter must be able to hold TIMEOUT.
  if (TIMEOUT < 1 || TIMEOUT >= (1 << TO_WIDTH)) begin : g_bad_timeout
    $error("imem_arbiter: TIMEOUT does not fit in TO_WIDTH bits");
  end

  arb_state_t state_q, state_d;
  logic       rr_q, rr_d;
  logic       winner;

  imem_arb_rr u_rr (
    .syn0   (a_i_syn0),
    .syn1   (a_i_syn1),
    .rr     (rr_q),
    .winner (winner)
  );

  // Read data is broadcast; requesters qualify it with their own ack.
  assign a_o_data0 = a_i_data;
  assign a_o_data1 = a_i_data;

`ifdef IMEM_ARB_TIMEOUT_EN
  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT - 1);

  logic [TO_WIDTH-1:0] to_cnt_q;
  logic                timeout_q;
  logic                timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    a_o_syn   = 1'b0;
    a_o_addr  = '0;
    a_o_ack0  = 1'b0;
    a_o_ack1  = 1'b0;
    a_o_last0 = 1'b0;
    a_o_last1 = 1'b0;
    a_o_grant = grant_for(state_q);
`ifdef IMEM_ARB_TIMEOUT_EN
    timeout_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (a_i_syn0 || a_i_syn1) begin
          state_d = winner ? ST_BUSY1 : ST_BUSY0;
          rr_d    = winner;
        end
      end

      ST_BUSY0: begin
        a_o_syn   = a_i_syn0;
        a_o_addr  = a_i_addr0;
        a_o_ack0  = a_i_ack;
        a_o_last0 = a_i_last;
        if (a_i_flush) begin
          if (a_i_ack) begin
            // The word belongs to a flushed fetch: hide it and release.
            a_o_ack0  = 1'b0;
            a_o_last0 = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (a_i_ack && a_i_last) begin
          state_d = ST_IDLE;
        end else if (!a_i_syn0 && !a_i_ack) begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY1: begin
        a_o_syn   = a_i_syn1;
        a_o_addr  = a_i_addr1;
        a_o_ack1  = a_i_ack;
        a_o_last1 = a_i_last;
        if (a_i_ack && a_i_last) begin
          state_d = ST_IDLE;
        end else if (!a_i_syn1 && !a_i_ack) begin
          state_d = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (a_i_ack) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef IMEM_ARB_TIMEOUT_EN
    // Forced release only when the FSM would otherwise keep waiting; a
    // normal exit in the same cycle is not reported as a timeout.
    if (state_q != ST_IDLE && state_d == state_q && !a_i_ack &&
        to_cnt_q == TO_LIMIT) begin
      state_d   = ST_IDLE;
      timeout_d = 1'b1;
    end
`endif

    // While reset is held, nothing leaks to memory or requesters,
    // including an ack that was in flight.
    if (a_rst) begin
      a_o_syn   = 1'b0;
      a_o_addr  = '0;
      a_o_ack0  = 1'b0;
      a_o_ack1  = 1'b0;
      a_o_last0 = 1'b0;
      a_o_last1 = 1'b0;
      a_o_grant = GRANT_NONE;
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

`ifdef IMEM_ARB_TIMEOUT_EN
  // Counts consecutive ack-less cycles inside one BUSY/DRAIN visit.
  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      if (state_q == ST_IDLE || state_d != state_q || a_i_ack) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TO_WIDTH'(1);
      end
    end
  end

  assign a_o_timeout = timeout_q;
`else
  assign a_o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  localparam int IW         = 32;
  localparam int AW         = 32;
  localparam int TB_TIMEOUT = 8;

  logic          a_clk = 1'b0;
  logic          a_rst;
  logic          a_i_syn0, a_i_syn1;
  logic [AW-1:0] a_i_addr0, a_i_addr1;
  logic          a_o_ack0, a_o_ack1, a_o_last0, a_o_last1;
  logic [IW-1:0] a_o_data0, a_o_data1;
  logic          a_o_syn;
  logic [AW-1:0] a_o_addr;
  logic          a_i_ack, a_i_last;
  logic [IW-1:0] a_i_data;
  logic          a_i_flush;
  logic [1:0]    a_o_grant;
  logic          a_o_timeout;

  typedef struct {
    logic          req;
    logic [IW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic          mon_req, mon_last;
  logic [IW-1:0] mon_data;

  int n_tests = 0;
  int n_fail  = 0;

  imem_arbiter #(
    .IWIDTH       (IW),
    .AWIDTH_INSTR (AW),
    .TIMEOUT      (TB_TIMEOUT),
    .TO_WIDTH     (7)
  ) dut (
    .a_clk       (a_clk),
    .a_rst       (a_rst),
    .a_i_syn0    (a_i_syn0),
    .a_i_syn1    (a_i_syn1),
    .a_i_addr0   (a_i_addr0),
    .a_i_addr1   (a_i_addr1),
    .a_o_ack0    (a_o_ack0),
    .a_o_ack1    (a_o_ack1),
    .a_o_last0   (a_o_last0),
    .a_o_last1   (a_o_last1),
    .a_o_data0   (a_o_data0),
    .a_o_data1   (a_o_data1),
    .a_o_syn     (a_o_syn),
    .a_o_addr    (a_o_addr),
    .a_i_ack     (a_i_ack),
    .a_i_last    (a_i_last),
    .a_i_data    (a_i_data),
    .a_i_flush   (a_i_flush),
    .a_o_grant   (a_o_grant),
    .a_o_timeout (a_o_timeout)
  );

  always #5 a_clk = ~a_clk;

  // Scoreboard consumer: every ack seen by a requester must match the
  // oldest expected routed word.
  always @(negedge a_clk) begin
    if (a_o_ack0 || a_o_ack1) begin
      n_tests++;
      if (a_o_ack0 && a_o_ack1) begin
        n_fail++;
        $display("FAIL sb_dual_ack: ack0=%b ack1=%b, required at most one", a_o_ack0, a_o_ack1);
      end else if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_ack: ack0=%b ack1=%b at %0t, required no ack", a_o_ack0, a_o_ack1, $time);
      end else begin
        mon_e    = sb_q.pop_front();
        mon_req  = a_o_ack1;
        mon_data = a_o_ack1 ? a_o_data1 : a_o_data0;
        mon_last = a_o_ack1 ? a_o_last1 : a_o_last0;
        if (mon_req !== mon_e.req || mon_data !== mon_e.data || mon_last !== mon_e.last) begin
          n_fail++;
          $display("FAIL sb_word: got req=%0d data=%h last=%b, expected req=%0d data=%h last=%b",
                   mon_req, mon_data, mon_last, mon_e.req, mon_e.data, mon_e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge a_clk);
    #1;
  endtask

  task automatic neg();
    @(negedge a_clk);
  endtask

  task automatic mem_ack(input logic req, input logic [IW-1:0] d, input logic l, input bit routed);
    exp_t e;
    a_i_ack  = 1'b1;
    a_i_last = l;
    a_i_data = d;
    if (routed) begin
      e.req  = req;
      e.data = d;
      e.last = l;
      sb_q.push_back(e);
    end
  endtask

  task automatic mem_idle();
    a_i_ack   = 1'b0;
    a_i_last  = 1'b0;
    a_i_flush = 1'b0;
  endtask

  task automatic do_reset();
    a_rst = 1'b1;
    cyc();
    cyc();
    a_rst = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1;
    a_i_syn0 = 1'b1;
    a_i_addr0 = 32'h55;
    cyc();
    neg();
    n_tests++;
    if (a_o_grant !== 2'b00 || a_o_syn !== 1'b0 || a_o_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b syn=%b addr=%h, required 00/0/0", a_o_grant, a_o_syn, a_o_addr);
    end
    n_tests++;
    if ({a_o_ack0, a_o_ack1, a_o_last0, a_o_last1, a_o_timeout} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_acks: ack/last/timeout=%b, required 00000",
               {a_o_ack0, a_o_ack1, a_o_last0, a_o_last1, a_o_timeout});
    end
    cyc();
    a_rst = 1'b0;
    a_i_syn0 = 1'b0;
    neg();
    n_tests++;
    if (a_o_grant !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: grant=%b, required 00", a_o_grant);
    end
  endtask

  task automatic test_single();
    cyc();
    a_i_syn0 = 1'b1;
    a_i_addr0 = 32'h100;
    neg();
    n_tests++;
    if (a_o_grant !== 2'b00 || a_o_syn !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency: grant=%b syn=%b, required 00/0", a_o_grant, a_o_syn);
    end
    cyc();
    neg();
    n_tests++;
    if (a_o_grant !== 2'b01 || a_o_syn !== 1'b1 || a_o_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b syn=%b addr=%h, required 01/1/100", a_o_grant, a_o_syn, a_o_addr);
    end
    cyc();
    neg();
    cyc();
    mem_ack(1'b0, 32'hA0A0_0001, 1'b1, 1'b1);
    neg();
    n_tests++;
    if (a_o_ack0 !== 1'b1 || a_o_last0 !== 1'b1 || a_o_ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack: ack0=%b last0=%b ack1=%b, required 1/1/0", a_o_ack0, a_o_last0, a_o_ack1);
    end
    cyc();
    mem_idle();
    a_i_syn0 = 1'b0;
    neg();
    n_tests++;
    if (a_o_grant !== 2'b00 || a_o_syn !== 1'b0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_release: grant=%b syn=%b pending=%0d, required 00/0/0", a_o_grant, a_o_syn, sb_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]    exp_g;
    logic [AW-1:0] exp_a;
    do_reset();
    cyc();
    a_i_syn0 = 1'b1;
    a_i_syn1 = 1'b1;
    a_i_addr0 = 32'h200;
    a_i_addr1 = 32'h300;
    for (int i = 0; i < 3; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (i % 2 == 0) ? 32'h200 : 32'h300;
      mem_idle();
      neg();
      n_tests++;
      if (a_o_grant !== 2'b00) begin
        n_fail++;
        $display("FAIL rr_gap%0d: grant=%b, required 00", i, a_o_grant);
      end
      cyc();
      mem_ack(exp_g[1], 32'hB000_0000 + IW'(i), 1'b1, 1'b1);
      neg();
      n_tests++;
      if (a_o_grant !== exp_g || a_o_addr !== exp_a) begin
        n_fail++;
        $display("FAIL rr_grant%0d: grant=%b addr=%h, required %b/%h", i, a_o_grant, a_o_addr, exp_g, exp_a);
      end
      cyc();
    end
    mem_idle();
    a_i_syn0 = 1'b0;
    a_i_syn1 = 1'b0;
    neg();
    n_tests++;
    if (a_o_grant !== 2'b00 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_end: grant=%b pending=%0d, required 00/0", a_o_grant, sb_q.size());
    end
  endtask

  task automatic test_stream1();
    cyc();
    a_i_syn1 = 1'b1;
    a_i_addr1 = 32'h400;
    neg();
    cyc();
    neg();
    n_tests++;
    if (a_o_grant !== 2'b10 || a_o_addr !== 32'h400) begin
      n_fail++;
      $display("FAIL stream_grant: grant=%b addr=%h, required 10/400", a_o_grant, a_o_addr);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      mem_ack(1'b1, 32'hC000_0000 + IW'(k), (k == 3), 1'b1);
      neg();
      n_tests++;
      if (a_o_grant !== 2'b10 || a_o_ack0 !== 1'b0 || a_o_ack1 !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_word%0d: grant=%b ack0=%b ack1=%b, required 10/0/1", k, a_o_grant, a_o_ack0, a_o_ack1);
      end
    end
    cyc();
    mem_idle();
    a_i_syn1 = 1'b0;
    neg();
    n_tests++;
    if (a_o_grant !== 2'b00 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_end: grant=%b pending=%0d, required 00/0", a_o_grant, sb_q.size());
    end
  endtask

  task automatic test_flush_drain();
    cyc();
    a_i_syn0 = 1'b1;
    a_i_addr0 = 32'h500;
    neg();
    cyc();
    neg();
    cyc();
    a_i_flush = 1'b1;
    neg();
    n_tests++;
    if (a_o_grant !== 2'b01 || a_o_ack0 !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_flush_cycle: grant=%b ack0=%b, required 01/0", a_o_grant, a_o_ack0);
    end
    cyc();
    a_i_flush = 1'b0;
    a_i_syn0 = 1'b0;
    neg();
    n_tests++;
    if (a_o_grant !== 2'b00 || a_o_syn !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_state: grant=%b syn=%b, required 00/0", a_o_grant, a_o_syn);
    end
    cyc();
    mem_ack(1'b0, 32'hD000_0001, 1'b1, 1'b0);
    neg();
    n_tests++;
    if (a_o_ack0 !== 1'b0 || a_o_ack1 !== 1'b0 || a_o_last0 !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_discard: ack0=%b ack1=%b last0=%b, required 0/0/0", a_o_ack0, a_o_ack1, a_o_last0);
    end
    cyc();
    mem_idle();
    a_i_syn1 = 1'b1;
    a_i_addr1 = 32'h510;
    neg();
    n_tests++;
    if (a_o_grant !== 2'b00 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_idle: grant=%b pending=%0d, required 00/0", a_o_grant, sb_q.size());
    end
    // Drain must have returned to IDLE so a new request is granted normally.
    cyc();
    neg();
    n_tests++;
    if (a_o_grant !== 2'b10) begin
      n_fail++;
      $display("FAIL drain_regrant: grant=%b, required 10", a_o_grant);
    end
    cyc();
    a_i_syn1 = 1'b0;
    neg();
    cyc();
  endtask

  task automatic test_flush_ack();
    cyc();
    a_i_syn0 = 1'b1;
    a_i_addr0 = 32'h600;
    neg();
    cyc();
    neg();
    cyc();
    a_i_flush = 1'b1;
    mem_ack(1'b0, 32'hE000_0001, 1'b0, 1'b0);
    neg();
    n_tests++;
    if (a_o_ack0 !== 1'b0 || a_o_ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL flushack_suppress: ack0=%b ack1=%b, required 0/0", a_o_ack0, a_o_ack1);
    end
    cyc();
    mem_idle();
    a_i_syn0 = 1'b0;
    neg();
    n_tests++;
    if (a_o_grant !== 2'b00 || a_o_syn !== 1'b0) begin
      n_fail++;
      $display("FAIL flushack_idle: grant=%b syn=%b, required 00/0", a_o_grant, a_o_syn);
    end
  endtask

  task automatic test_flush_busy1();
    cyc();
    a_i_syn1 = 1'b1;
    a_i_addr1 = 32'h680;
    neg();
    cyc();
    a_i_flush = 1'b1;
    neg();
    cyc();
    a_i_flush = 1'b0;
    neg();
    n_tests++;
    if (a_o_grant !== 2'b10 || a_o_syn !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_busy1: grant=%b syn=%b, required 10/1", a_o_grant, a_o_syn);
    end
    cyc();
    mem_ack(1'b1, 32'hE100_0001, 1'b1, 1'b1);
    neg();
    cyc();
    mem_idle();
    a_i_syn1 = 1'b0;
    neg();
    n_tests++;
    if (a_o_grant !== 2'b00 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL flush_busy1_end: grant=%b pending=%0d, required 00/0", a_o_grant, sb_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    cyc();
    a_i_syn1 = 1'b1;
    a_i_addr1 = 32'h700;
    neg();
    cyc();
    neg();
    cyc();
    a_rst = 1'b1;
    mem_ack(1'b1, 32'hF000_0001, 1'b0, 1'b0);
    neg();
    n_tests++;
    if (a_o_ack1 !== 1'b0 || a_o_ack0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_ack: ack0=%b ack1=%b, required 0/0", a_o_ack0, a_o_ack1);
    end
    cyc();
    a_rst = 1'b0;
    mem_idle();
    a_i_syn1 = 1'b0;
    neg();
    n_tests++;
    if (a_o_grant !== 2'b00 || a_o_syn !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle: grant=%b syn=%b, required 00/0", a_o_grant, a_o_syn);
    end
  endtask

  task automatic test_timeout();
    cyc();
    a_i_syn0 = 1'b1;
    a_i_addr0 = 32'h800;
    neg();
`ifdef IMEM_ARB_TIMEOUT_EN
    for (int n = 0; n < TB_TIMEOUT; n++) begin
      cyc();
      neg();
      n_tests++;
      if (a_o_grant !== 2'b01 || a_o_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_busy%0d: grant=%b timeout=%b, required 01/0", n, a_o_grant, a_o_timeout);
      end
    end
    cyc();
    a_i_syn0 = 1'b0;
    neg();
    n_tests++;
    if (a_o_timeout !== 1'b1 || a_o_grant !== 2'b00 || a_o_syn !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: timeout=%b grant=%b syn=%b, required 1/00/0", a_o_timeout, a_o_grant, a_o_syn);
    end
    cyc();
    neg();
    n_tests++;
    if (a_o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_width: timeout=%b, required 0", a_o_timeout);
    end
`else
    for (int n = 0; n < 3 * TB_TIMEOUT; n++) begin
      cyc();
      neg();
      n_tests++;
      if (a_o_grant !== 2'b01 || a_o_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_busy%0d: grant=%b timeout=%b, required 01/0", n, a_o_grant, a_o_timeout);
      end
    end
    cyc();
    a_i_syn0 = 1'b0;
    neg();
    cyc();
    neg();
    n_tests++;
    if (a_o_grant !== 2'b00) begin
      n_fail++;
      $display("FAIL hold_withdraw: grant=%b, required 00", a_o_grant);
    end
`endif
  endtask

  initial begin
    a_rst = 1'b1;
    a_i_syn0 = 1'b0;
    a_i_syn1 = 1'b0;
    a_i_addr0 = '0;
    a_i_addr1 = '0;
    a_i_ack = 1'b0;
    a_i_last = 1'b0;
    a_i_data = '0;
    a_i_flush = 1'b0;

    test_reset();
    test_single();
    test_round_robin();
    test_stream1();
    test_flush_drain();
    test_flush_ack();
    test_flush_busy1();
    test_reset_mid_burst();
    test_timeout();

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: pending=%0d, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
